level_judge: RTL and testbench

//   Per-level referee directly upstream of the game FSM; drives its levelPassed/lose inputs.
//   - Arms on each new level.
//   - Counts goals collected, lives lost and time remaining.
//   - Holds levelPassed high through a banner interval so the FSM can show its win-level/win-world status.
//   - Drops levelPassed afterwards so the FSM resumes play.

---
 rtl/level_judge.sv | 181 ++++++++++++++++++
 tb/tb_level_judge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_judge.sv
// rtl/level_judge.sv - per-level referee driving the game FSM's levelPassed/lose inputs
// Optional countdown timer enabled by defining LEVEL_JUDGE_TIMEOUT_EN.
module level_judge #(
    parameter int BASE_GOALS   = 3,
    parameter int WORLD_BONUS  = 2,
    parameter int LIVES        = 3,
    parameter int TIME_LIMIT   = 60,
    parameter int TIME_STEP    = 5,
    parameter int MIN_TIME     = 10,
    parameter int BANNER_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       goalHit,
    input  logic       hazardHit,
    input  logic [2:0] level,
    input  logic       world,
    input  logic [2:0] gameStatus,
    output logic       levelPassed,
    output logic       lose,
    output logic [3:0] goalsLeft,
    output logic [1:0] livesLeft,
    output logic [6:0] timeLeft
);

    localparam int BW = (BANNER_TICKS > 1) ? $clog2(BANNER_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_PASS,
        S_HOLD,
        S_DEAD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    goals_q, goals_d;
    logic [1:0]    lives_q, lives_d;
    logic [BW-1:0] banner_q, banner_d;
    logic          passed_q, passed_d;
    logic          lose_q, lose_d;

    logic [3:0] goals_load;
    logic [7:0] step_prod;
    logic [7:0] time_diff;
    logic [7:0] time_load;

    assign goals_load = 4'(BASE_GOALS) + 4'(level) + (world ? 4'(WORLD_BONUS) : 4'd0);

    // 8-bit subtraction is clamped to MIN_TIME, including the underflow case
    always_comb begin
        step_prod = 8'(TIME_STEP) * 8'(level);
        time_diff = 8'(TIME_LIMIT) - step_prod;
        time_load = time_diff;
        if (step_prod >= 8'(TIME_LIMIT) || time_diff < 8'(MIN_TIME)) begin
            time_load = 8'(MIN_TIME);
        end
    end

`ifdef LEVEL_JUDGE_TIMEOUT_EN
    logic [6:0] time_q, time_d;
`else
    logic unused_time;
    assign unused_time = ^time_load;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            goals_q  <= '0;
            lives_q  <= '0;
            banner_q <= '0;
            passed_q <= 1'b0;
            lose_q   <= 1'b0;
`ifdef LEVEL_JUDGE_TIMEOUT_EN
            time_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            goals_q  <= goals_d;
            lives_q  <= lives_d;
            banner_q <= banner_d;
            passed_q <= passed_d;
            lose_q   <= lose_d;
`ifdef LEVEL_JUDGE_TIMEOUT_EN
            time_q   <= time_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        goals_d  = goals_q;
        lives_d  = lives_q;
        banner_d = banner_q;
        passed_d = passed_q;
        lose_d   = lose_q;
`ifdef LEVEL_JUDGE_TIMEOUT_EN
        time_d   = time_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gameStatus == 3'd0) begin
                    goals_d  = goals_load;
                    lives_d  = 2'(LIVES);
                    passed_d = 1'b0;
                    lose_d   = 1'b0;
                    state_d  = S_PLAY;
`ifdef LEVEL_JUDGE_TIMEOUT_EN
                    time_d   = 7'(time_load);
`endif
                end
            end
            S_PLAY: begin
                if (gameStatus == 3'd3 || gameStatus == 3'd4) begin
                    state_d = S_IDLE;
                end else if (goalHit && goals_q == 4'd1) begin
                    // winning goal freezes lives and time even if other events coincide
                    goals_d  = 4'd0;
                    passed_d = 1'b1;
                    state_d  = S_PASS;
                end else begin
                    if (goalHit && goals_q != 4'd0) begin
                        goals_d = goals_q - 4'd1;
                    end
                    if (hazardHit && lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            lose_d  = 1'b1;
                            state_d = S_DEAD;
                        end
                    end
`ifdef LEVEL_JUDGE_TIMEOUT_EN
                    if (tick && time_q != 7'd0) begin
                        time_d = time_q - 7'd1;
                        if (time_q == 7'd1 && goals_d != 4'd0) begin
                            lose_d  = 1'b1;
                            state_d = S_DEAD;
                        end
                    end
`endif
                end
            end
            S_PASS: begin
                if (gameStatus == 3'd1 || gameStatus == 3'd2) begin
                    banner_d = '0;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (banner_q == BW'(BANNER_TICKS - 1)) begin
                        banner_d = '0;
                        passed_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        banner_d = banner_q + BW'(1);
                    end
                end
            end
            S_DEAD: begin
                lose_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign levelPassed = passed_q;
    assign lose        = lose_q;
    assign goalsLeft   = goals_q;
    assign livesLeft   = lives_q;
`ifdef LEVEL_JUDGE_TIMEOUT_EN
    assign timeLeft    = time_q;
`else
    assign timeLeft    = 7'd0;
`endif

endmodule

// File: tb/tb_level_judge.sv
// tb/tb_level_judge.sv - directed and randomized checks of level_judge against a behavioural model
module tb_level_judge;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       goalHit;
    logic       hazardHit;
    logic [2:0] level;
    logic       world;
    logic [2:0] gameStatus;
    logic       levelPassed;
    logic       lose;
    logic [3:0] goalsLeft;
    logic [1:0] livesLeft;
    logic [6:0] timeLeft;

    int errors = 0;
    int checks = 0;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_PASS = 2;
    localparam int M_HOLD = 3;
    localparam int M_DEAD = 4;

    int m_st, m_goals, m_lives, m_time, m_banner, m_pass, m_lose;

`ifdef LEVEL_JUDGE_TIMEOUT_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    level_judge dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .goalHit    (goalHit),
        .hazardHit  (hazardHit),
        .level      (level),
        .world      (world),
        .gameStatus (gameStatus),
        .levelPassed(levelPassed),
        .lose       (lose),
        .goalsLeft  (goalsLeft),
        .livesLeft  (livesLeft),
        .timeLeft   (timeLeft)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_goals = 0; m_lives = 0; m_time = 0;
        m_banner = 0; m_pass = 0; m_lose = 0;
    endtask

    task automatic model_step(input bit t, input bit g, input bit h, input int lv, input bit w, input int gs);
        int full_time;
        bit win;
        full_time = 60 - 5 * lv;
        if (full_time < 10) full_time = 10;
        case (m_st)
            M_IDLE: if (gs == 0) begin
                m_goals = 3 + lv + (w ? 2 : 0);
                m_lives = 3;
                m_time  = TIMER ? full_time : 0;
                m_pass  = 0;
                m_lose  = 0;
                m_st    = M_PLAY;
            end
            M_PLAY: begin
                win = g && m_goals == 1;
                if (gs == 3 || gs == 4) begin
                    m_st = M_IDLE;
                end else if (win) begin
                    m_goals = 0;
                    m_pass  = 1;
                    m_st    = M_PASS;
                end else begin
                    m_goals = m_goals - ((g && m_goals > 0) ? 1 : 0);
                    if (h && m_lives > 0) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) begin m_lose = 1; m_st = M_DEAD; end
                    end
                    if (TIMER && t && m_time > 0) begin
                        m_time = m_time - 1;
                        if (m_time == 0 && m_goals > 0) begin m_lose = 1; m_st = M_DEAD; end
                    end
                end
            end
            M_PASS: if (gs == 1 || gs == 2) begin
                m_banner = 0;
                m_st = M_HOLD;
            end
            M_HOLD: if (t) begin
                m_banner = m_banner + 1;
                if (m_banner == 2) begin m_pass = 0; m_st = M_IDLE; end
            end
            default: ;
        endcase
    endtask

    task automatic compare(input string tag);
        check({tag, ".levelPassed"}, int'(levelPassed), m_pass);
        check({tag, ".lose"},        int'(lose),        m_lose);
        check({tag, ".goalsLeft"},   int'(goalsLeft),   m_goals);
        check({tag, ".livesLeft"},   int'(livesLeft),   m_lives);
        check({tag, ".timeLeft"},    int'(timeLeft),    m_time);
    endtask

    task automatic step(input string tag, input bit t, input bit g, input bit h,
                        input int lv, input bit w, input int gs);
        tick = t; goalHit = g; hazardHit = h;
        level = 3'(lv); world = w; gameStatus = 3'(gs);
        @(posedge clk); #1;
        model_step(t, g, h, lv, w, gs);
        compare(tag);
    endtask

    // reset is asserted between edges so the asynchronous clear is checked before any clock
    task automatic apply_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare({tag, ".async"});
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; goalHit = 1'b0; hazardHit = 1'b0;
        level = 3'd0; world = 1'b0; gameStatus = 3'd0;
        model_reset();
        @(posedge clk); #1;
        compare("reset");
        reset = 1'b0;

        // arm level 0
        step("arm0", 0, 0, 0, 0, 0, 0);
        check("arm0.goals", int'(goalsLeft), 3);
        check("arm0.lives", int'(livesLeft), 3);
        check("arm0.time",  int'(timeLeft), TIMER ? 60 : 0);

        // three goals, banner handshake, next level
        for (int i = 0; i < 3; i++) step("goal", 0, 1, 0, 0, 0, 0);
        check("win.passed", int'(levelPassed), 1);
        step("ack", 0, 0, 0, 0, 0, 1);
        step("ban1", 1, 0, 0, 0, 0, 1);
        check("ban1.passed", int'(levelPassed), 1);
        step("ban2", 1, 0, 0, 0, 0, 1);
        check("ban2.passed", int'(levelPassed), 0);
        step("arm1", 0, 0, 0, 1, 0, 0);
        check("arm1.goals", int'(goalsLeft), 4);
        check("arm1.time",  int'(timeLeft), TIMER ? 55 : 0);

        // level 6 world 1, killed by hazards, then goals ignored
        apply_reset("r3");
        step("arm6", 0, 0, 0, 6, 1, 0);
        check("arm6.goals", int'(goalsLeft), 11);
        check("arm6.time",  int'(timeLeft), TIMER ? 30 : 0);
        for (int i = 0; i < 3; i++) step("haz", 0, 0, 1, 6, 1, 0);
        check("dead.lose", int'(lose), 1);
        for (int i = 0; i < 3; i++) step("dead.goal", 0, 1, 0, 6, 1, 0);
        check("dead.goals", int'(goalsLeft), 11);
        check("dead.lose2", int'(lose), 1);

        // final goal and fatal hazard together
        apply_reset("r4");
        step("arm4", 0, 0, 0, 0, 0, 0);
        step("g1", 0, 1, 0, 0, 0, 0);
        step("g2", 0, 1, 0, 0, 0, 0);
        step("h1", 0, 0, 1, 0, 0, 0);
        step("h2", 0, 0, 1, 0, 0, 0);
        step("both", 0, 1, 1, 0, 0, 0);
        check("both.passed", int'(levelPassed), 1);
        check("both.lose",   int'(lose), 0);
        check("both.lives",  int'(livesLeft), 1);

        // countdown expiry
        apply_reset("r5");
        step("arm5", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) step("tick", 1, 0, 0, 0, 0, 0);
        check("tmo.time", int'(timeLeft), 0);
        check("tmo.lose", int'(lose), TIMER ? 1 : 0);

        // reset while holding the banner, then re-arm
        apply_reset("r6a");
        step("arm6b", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("goal6", 0, 1, 0, 0, 0, 0);
        step("ack6", 0, 0, 0, 0, 0, 2);
        step("hold6", 1, 0, 0, 0, 0, 2);
        check("hold6.passed", int'(levelPassed), 1);
        gameStatus = 3'd0;
        apply_reset("r6b");
        step("rearm", 0, 0, 0, 0, 0, 0);
        check("rearm.goals", int'(goalsLeft), 3);
        check("rearm.lives", int'(livesLeft), 3);
        check("rearm.time",  int'(timeLeft), TIMER ? 60 : 0);

        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            int tdiv;
            tdiv = int'($urandom_range(1, 4));
            apply_reset("rnd.rst");
            for (int c = 0; c < 150; c++) begin
                int r, gsr, gs;
                bit t, g, h;
                t   = ($urandom % tdiv) == 0;
                r   = int'($urandom % 12);
                g   = (r < 2);
                h   = (r == 2);
                gsr = int'($urandom % 20);
                gs  = (gsr < 13) ? 0 : (gsr < 16) ? 1 : (gsr < 18) ? 2 : (gsr == 18) ? 3 : 4;
                step("rnd", t, g, h, int'($urandom % 8), bit'($urandom % 2), gs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
